t_circuit: RTL and testbench

Two-bit synchronous up-counter built from two T flip-flops (A = MSB, B = LSB) that advances one step per clock while enable input `x` is high and holds while `x` is low. Output `y` flags the all-ones state (A·B = 1). It serves as a small control/sequence detector in the sequential-logic section of the design and as a reference Moore machine for bench bring-up.

---
 rtl/t_circuit_pkg.sv | 14 +
 rtl/t_circuit_t_ff.sv | 17 +
 rtl/t_circuit.sv | 53 +++++
 tb/tb_t_circuit.sv | 119 +++++++++++
 4 files changed

// File: rtl/t_circuit_pkg.sv
// Shared state encoding and reset defaults for the two-bit T flip-flop counter.
package t_circuit_pkg;

  typedef enum logic [1:0] {
    ST_00 = 2'b00,
    ST_01 = 2'b01,
    ST_10 = 2'b10,
    ST_11 = 2'b11
  } state_t;

  localparam logic RESET_A_DEF = 1'b0;
  localparam logic RESET_B_DEF = 1'b0;

endpackage

// File: rtl/t_circuit_t_ff.sv
// T flip-flop with synchronous active-high reset to a supplied value.
module t_ff (
  input  logic CLK,
  input  logic RST,
  input  logic T,
  input  logic RST_VAL,
  output logic Q
);

  always_ff @(posedge CLK) begin
    if (RST)
      Q <= RST_VAL;
    else if (T)
      Q <= ~Q;
  end

endmodule

// File: rtl/t_circuit.sv
// Two-bit enable-driven up-counter from two T flip-flops; y flags state 11.
// Define T_CIRCUIT_SAT_EN to saturate at 11 instead of wrapping to 00.
module t_circuit
  import t_circuit_pkg::*;
#(
  parameter logic RESET_A = RESET_A_DEF,
  parameter logic RESET_B = RESET_B_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic x,
  output logic y,
  output logic A,
  output logic B
);

  logic ta;
  logic tb;
  state_t state;

  assign state = state_t'({A, B});

  always_comb begin
    ta = 1'b0;
    tb = 1'b0;
`ifdef T_CIRCUIT_SAT_EN
    ta = x & B & ~A;
    tb = x & (state != ST_11);
`else
    ta = x & B;
    tb = x;
`endif
  end

  assign y = (state == ST_11);

  t_ff u_ff_a (
    .CLK     (CLK),
    .RST     (RST),
    .T       (ta),
    .RST_VAL (RESET_A),
    .Q       (A)
  );

  t_ff u_ff_b (
    .CLK     (CLK),
    .RST     (RST),
    .T       (tb),
    .RST_VAL (RESET_B),
    .Q       (B)
  );

endmodule

// File: tb/tb_t_circuit.sv
// Self-checking bench for t_circuit: directed steps then random stimulus vs. an integer counter model.
module tb_t_circuit;

  logic CLK;
  logic RST;
  logic x;
  logic y;
  logic A;
  logic B;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned model_cnt = 0;

  t_circuit #(
    .RESET_A (1'b0),
    .RESET_B (1'b0)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .x   (x),
    .y   (y),
    .A   (A),
    .B   (B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count value as a plain integer: reset -> 0, enable -> +1 (wrap or clamp at 3).
  task automatic step(input logic rst_v, input logic x_v, input string tag);
    logic exp_a;
    logic exp_b;
    logic exp_y;
    @(negedge CLK);
    RST = rst_v;
    x   = x_v;
    @(posedge CLK);
    if (rst_v)
      model_cnt = 0;
    else if (x_v) begin
`ifdef T_CIRCUIT_SAT_EN
      if (model_cnt < 3) model_cnt = model_cnt + 1;
`else
      model_cnt = (model_cnt + 1) % 4;
`endif
    end
    exp_a = (model_cnt >= 2);
    exp_b = (model_cnt % 2) == 1;
    exp_y = (model_cnt == 3);
    #1;
    checks++;
    assert (A === exp_a) else begin
      errors++;
      $error("FAIL %s A: observed=%b expected=%b", tag, A, exp_a);
    end
    checks++;
    assert (B === exp_b) else begin
      errors++;
      $error("FAIL %s B: observed=%b expected=%b", tag, B, exp_b);
    end
    checks++;
    assert (y === exp_y) else begin
      errors++;
      $error("FAIL %s y: observed=%b expected=%b", tag, y, exp_y);
    end
  endtask

  initial begin
    RST = 1'b1;
    x   = 1'b1;

    // Reset overrides enable.
    step(1'b1, 1'b1, "reset");
    checks++;
    assert ({A, B, y} === 3'b000) else begin
      errors++;
      $error("FAIL reset_const: observed=%b expected=000", {A, B, y});
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold");

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "count");
`ifndef T_CIRCUIT_SAT_EN
    checks++;
    assert ({A, B} === 2'b00) else begin
      errors++;
      $error("FAIL wrap_const: observed=%b expected=00", {A, B});
    end
`endif

    // Alternating enable, x changed mid-cycle.
    step(1'b1, 1'b0, "realign");
    for (int i = 0; i < 8; i++) step(1'b0, (i % 2) == 1, "alternate");

    // Reset mid-count from state 10.
    step(1'b1, 1'b0, "pre_mid");
    step(1'b0, 1'b1, "to_01");
    step(1'b0, 1'b1, "to_10");
    step(1'b1, 1'b1, "mid_reset");
    step(1'b0, 1'b1, "release");
    checks++;
    assert ({A, B} === 2'b01) else begin
      errors++;
      $error("FAIL release_const: observed=%b expected=01", {A, B});
    end

    // Saturate/wrap run: five enabled edges from 00.
    step(1'b1, 1'b0, "pre_run");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "run5");

    for (int i = 0; i < 300; i++)
      step(($urandom % 16) == 0, $urandom_range(0, 1) == 1, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
